// File: rtl/led_scan_gen.sv
// Raster scan generator: walks row_now/col_now over every panel pixel and emits latch/blanking strobes between rows.
// Latency: coordinates are registered and advance on the edge after an accept. The first pixel appears one edge after en is sampled high.
// Backpressure: pix_ready low in SCAN holds the coordinate indefinitely. pix_ready is ignored outside SCAN.
//
// Ports:
//   clk, rst          - single clock; asynchronous active-high reset
//   en                - level-sensitive scan enable; a row in progress always completes
//   pix_ready         - downstream accepts the current coordinate
//   row_now, col_now  - current pixel address
//   pix_valid         - coordinate is a live pixel (SCAN only)
//   line_start        - pulse on the first SCAN cycle of each row
//   frame_start       - line_start for row 0
//   latch, oe_n       - panel driver strobes; oe_n is high (blanked) outside SCAN
//   frame_cnt         - completed-frame counter, wraps mod 256
//   busy              - FSM is not parked in IDLE
module led_scan_gen #(
    parameter int COLS      = 97,
    parameter int ROWS      = 64,
    parameter int BLANK_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pix_ready,
    output logic [6:0] row_now,
    output logic [6:0] col_now,
    output logic       pix_valid,
    output logic       line_start,
    output logic       frame_start,
    output logic       latch,
    output logic       oe_n,
    output logic [7:0] frame_cnt,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SCAN, LATCH, BLANK} state_t;

    localparam logic [6:0] COL_LAST   = 7'(COLS - 1);
    localparam logic [6:0] ROW_LAST   = 7'(ROWS - 1);
    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYC);

    state_t     state;
    logic [7:0] blank_cnt;
    logic [6:0] row_next;
    logic       row_wrap;

    always_comb begin
        row_wrap = (row_now == ROW_LAST);
        row_next = row_wrap ? 7'd0 : row_now + 7'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            blank_cnt   <= 8'd0;
            row_now     <= 7'd0;
            col_now     <= 7'd0;
            pix_valid   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            latch       <= 1'b0;
            oe_n        <= 1'b1;
            frame_cnt   <= 8'd0;
            busy        <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state below re-asserts them.
            latch       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;

            case (state)
                IDLE: begin
                    pix_valid <= 1'b0;
                    oe_n      <= 1'b1;
                    if (en) begin
                        // Resume on whatever row we parked at, always from column 0.
                        state       <= SCAN;
                        col_now     <= 7'd0;
                        pix_valid   <= 1'b1;
                        oe_n        <= 1'b0;
                        line_start  <= 1'b1;
                        frame_start <= (row_now == 7'd0);
                        busy        <= 1'b1;
                    end
                end

                SCAN: begin
                    if (pix_valid && pix_ready) begin
                        if (col_now == COL_LAST) begin
                            state     <= LATCH;
                            col_now   <= 7'd0;
                            latch     <= 1'b1;
                            oe_n      <= 1'b1;
                            pix_valid <= 1'b0;
                        end else begin
                            col_now <= col_now + 7'd1;
                        end
                    end
                end

                LATCH: begin
                    state     <= BLANK;
                    blank_cnt <= BLANK_LOAD;
                end

                BLANK: begin
                    if (blank_cnt == 8'd1) begin
                        row_now <= row_next;
                        if (row_wrap) begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                        // en is only consulted here, so a mid-row drop finishes the row first.
                        if (en) begin
                            state       <= SCAN;
                            pix_valid   <= 1'b1;
                            oe_n        <= 1'b0;
                            line_start  <= 1'b1;
                            frame_start <= (row_next == 7'd0);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        blank_cnt <= blank_cnt - 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/led_scan_gen.md
# led_scan_gen

Raster scan generator for the LED panel pipeline. It steps `row_now`/`col_now` over every panel pixel and feeds the area-classification stages that decode those coordinates into region flags. It paces the scan with a valid/ready handshake toward the pixel shift-out path. Between rows it produces the latch and output-enable (blanking) strobes for the panel drivers, and it counts frames.

## Interface
- `COLS`, default 97: pixels per row; column addresses run 0..COLS-1, max 128.
- `ROWS`, default 64: rows per frame; row addresses run 0..ROWS-1, max 128.
- `BLANK_CYC`, default 4: blanking cycles after the latch pulse, min 1, max 255.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: scan enable, level-sensitive.
- `pix_ready` in 1: downstream accepts the current coordinate.
- `row_now` out 7: current row address.
- `col_now` out 7: current column address.
- `pix_valid` out 1: `row_now`/`col_now` are a live pixel.
- `line_start` out 1: one-cycle pulse on the first valid cycle of each row.
- `frame_start` out 1: one-cycle pulse coincident with `line_start` when `row_now`==0.
- `latch` out 1: one-cycle panel latch strobe.
- `oe_n` out 1: panel output enable, active low.
- `frame_cnt` out 8: completed-frame counter.
- `busy` out 1: high in any state other than IDLE.

## Operation
- All outputs are registered.
- Reset values: `row_now`=0, `col_now`=0, `pix_valid`=0, `line_start`=0, `frame_start`=0, `latch`=0, `oe_n`=1, `frame_cnt`=0, `busy`=0, state=IDLE.
- The FSM has four states: IDLE, SCAN, LATCH, BLANK.
- IDLE:
  - `pix_valid`=0, `oe_n`=1, coordinates held.
  - `en`=1 → SCAN. The row is the current `row_now` (0 after reset) and `col_now` is set to 0.
- SCAN:
  - `pix_valid`=1 and `oe_n`=0, so the previously latched row is displayed.
  - An accept is a cycle with `pix_valid`&&`pix_ready`.
  - On accept with `col_now`<COLS-1, `col_now` increments.
  - On accept with `col_now`==COLS-1 → LATCH and `col_now` is set to 0.
  - With `pix_ready`=0, `row_now`/`col_now` hold indefinitely.
- LATCH:
  - Lasts one cycle with `latch`=1, `oe_n`=1, `pix_valid`=0.
  - Always → BLANK.
- BLANK:
  - Lasts exactly BLANK_CYC cycles with `oe_n`=1 and `pix_valid`=0.
  - On the last cycle, `row_now` advances.
  - At `row_now`==ROWS-1 it wraps to 0 and `frame_cnt` increments (mod 256).
  - Then → SCAN if `en`=1, otherwise → IDLE.
- `line_start` is high on the first SCAN cycle of each row. `frame_start` is `line_start` && `row_now`==0.
- Deasserting `en` mid-row does not truncate the row. The current row completes through LATCH and BLANK, then the FSM parks in IDLE with `row_now` at the next row. Re-enabling resumes from that row.
- The handshake does not depend on `en`: `pix_ready` is ignored outside SCAN.
- The blank counter is 8-bit and is reloaded on entry to BLANK.

## Timing
- With `en` rising at edge N, the first `pix_valid`/`line_start` is visible after edge N+1.
- Coordinate latency: a new coordinate appears on the edge after its accept cycle. There is no combinational path from `pix_ready` to the outputs.
- With `pix_ready` held high, row period = COLS + 1 + BLANK_CYC cycles (102 at defaults). Frame period = ROWS × row period (6528 at defaults).
- `latch` rises on the edge after the accept of col COLS-1. `oe_n` goes high on that same edge.
- `oe_n` returns low together with `pix_valid` on the first SCAN cycle of the next row.
- Asserting `rst` at any time forces the reset values immediately, without waiting for a clock edge. Scan restarts from row 0 col 0 after release once `en`=1.

## Test plan
- **Free run.** Stimulus: reset, then `en`=1 and `pix_ready`=1 for 2 frames at defaults. Required response:
  - `line_start` every 102 cycles; `frame_start` every 6528 cycles.
  - `frame_cnt` reads 2.
  - Each row shows cols 0..96 exactly once.
  - `latch` is exactly 1 cycle; `oe_n` is high for 5 cycles per row.
- **Backpressure.** Stimulus: drop `pix_ready` for 10 cycles at col 40 and for 3 cycles at col 96. Required response: coordinates hold; no column is skipped or duplicated; the row period grows by exactly 13.
- **Enable drop mid-row.** Stimulus: `en`=0 at row 5 col 20. Required response:
  - Row 5 completes, then latch, then 4 blank cycles, then IDLE.
  - `row_now`=6, `busy`=0, `oe_n`=1.
  - Re-enabling gives `line_start` with row 6, col 0 and no `frame_start`.
- **Wrap.** Stimulus: set ROWS=3, COLS=4, BLANK_CYC=1. Required response: row sequence 0,1,2,0; `frame_start` on each return to row 0; `frame_cnt` increments after row 2's blank; row period = 6.
- **Async reset.** Stimulus: assert `rst` between edges mid-SCAN at row 10 col 50. Required response: all outputs at their reset values before the next edge; after release with `en`=1, the scan restarts at row 0 col 0 with `frame_start`.
- **frame_cnt rollover.** Stimulus: run 256 frames with ROWS=1, COLS=2. Required response: `frame_cnt` wraps 255→0.
